generic_sc_word_packer: RTL and testbench

Single-clock upstream packer for the width-adapting single-clock FIFO. It collects `DATA_RATIO` narrow words from a valid/ready stream into one wide word and writes that word into the FIFO write port, so the FIFO's narrow read side returns the words in their original order. A `snk_last_i` beat closes a partial wide word by padding the unused lanes. A one-word output holding register absorbs FIFO back-pressure.

---
 rtl/generic_sc_word_packer.sv | 76 +++++++
 tb/tb_generic_sc_word_packer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_sc_word_packer.sv
// generic_sc_word_packer
// Collects DATA_RATIO narrow beats into one wide word (lane 0 = first beat)
// and hands it to a width-adapting FIFO write port through a one-word
// holding register that absorbs FIFO back-pressure.
module generic_sc_word_packer #(
   parameter int unsigned           IN_DATA_W  = 32,
   parameter int unsigned           OUT_DATA_W = 256,
   parameter int unsigned           DATA_RATIO = OUT_DATA_W / IN_DATA_W,
   parameter int unsigned           EXTEND_W   = $clog2(DATA_RATIO),
   parameter logic [IN_DATA_W-1:0]  PAD_VALUE  = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  snk_valid_i,
   input  logic [IN_DATA_W-1:0]  snk_data_i,
   input  logic                  snk_last_i,
   output logic                  snk_ready_o,
   input  logic                  fifo_full_i,
   output logic                  fifo_wr_en_o,
   output logic [OUT_DATA_W-1:0] fifo_wr_data_o,
   output logic                  busy_o
);

   localparam logic [EXTEND_W-1:0] LAST_LANE = EXTEND_W'(DATA_RATIO - 1);
   localparam logic [DATA_RATIO-1:0][IN_DATA_W-1:0] PAD_WORD = {DATA_RATIO{PAD_VALUE}};

   logic [EXTEND_W-1:0]                  lane_cnt;
   logic [DATA_RATIO-1:0][IN_DATA_W-1:0] asm_q;
   logic [DATA_RATIO-1:0][IN_DATA_W-1:0] new_word;
   logic [OUT_DATA_W-1:0]                out_data;
   logic                                 out_valid;
   logic                                 accept;
   logic                                 complete;

   assign fifo_wr_en_o   = out_valid && !fifo_full_i;
   assign fifo_wr_data_o = out_data;
   assign snk_ready_o    = !(out_valid && fifo_full_i);
   assign accept         = snk_valid_i && snk_ready_o;
   assign complete       = accept && ((lane_cnt == LAST_LANE) || snk_last_i);
   assign busy_o         = (lane_cnt != '0) || out_valid;

   // Completed word: lanes above lane_cnt already hold PAD_VALUE in asm_q.
   always_comb begin
      new_word           = asm_q;
      new_word[lane_cnt] = snk_data_i;
   end

   // Assembly lanes and lane counter; a completion re-pads every lane.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lane_cnt <= '0;
         asm_q    <= PAD_WORD;
      end else if (complete) begin
         lane_cnt <= '0;
         asm_q    <= PAD_WORD;
      end else if (accept) begin
         lane_cnt        <= lane_cnt + EXTEND_W'(1);
         asm_q[lane_cnt] <= snk_data_i;
      end
   end

   // Output holding register; a new completion overrides the clear caused
   // by a same-cycle write so back-to-back wide words keep out_valid high.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (complete) begin
         out_data  <= new_word;
         out_valid <= 1'b1;
      end else if (fifo_wr_en_o) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_generic_sc_word_packer.sv
// Scoreboard bench for generic_sc_word_packer (32-bit lanes, 128-bit words).
module tb_generic_sc_word_packer;

   localparam int IW = 32;
   localparam int OW = 128;
   localparam int R  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          snk_valid = 1'b0;
   logic [IW-1:0] snk_data = '0;
   logic          snk_last = 1'b0;
   logic          snk_ready;
   logic          fifo_full = 1'b0;
   logic          fifo_wr_en;
   logic [OW-1:0] fifo_wr_data;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int wr_count = 0;
   int stalls = 0;
   int base;

   logic [OW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   int            wr_cyc_hist[$];
   logic [IW-1:0] m_asm[R];
   int            m_idx = 0;

   generic_sc_word_packer #(
      .IN_DATA_W (IW),
      .OUT_DATA_W(OW),
      .DATA_RATIO(R),
      .EXTEND_W  (2),
      .PAD_VALUE (32'h0)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .snk_valid_i   (snk_valid),
      .snk_data_i    (snk_data),
      .snk_last_i    (snk_last),
      .snk_ready_o   (snk_ready),
      .fifo_full_i   (fifo_full),
      .fifo_wr_en_o  (fifo_wr_en),
      .fifo_wr_data_o(fifo_wr_data),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Write-side monitor: pop the scoreboard on every FIFO write.
   always @(negedge clk) begin
      if (!rst && fifo_wr_en) begin
         logic [OW-1:0] e;
         int            ec;
         wr_count++;
         wr_cyc_hist.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_write", {{(OW-1){1'b0}}, fifo_wr_en}, '0);
         end else begin
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("wr_data", fifo_wr_data, e);
            if (ec >= 0) check("wr_cycle", cyc, ec);
         end
      end
   end

   task automatic model_reset();
      m_idx = 0;
      foreach (m_asm[i]) m_asm[i] = '0;
      exp_q.delete();
      exp_cyc_q.delete();
   endtask

   task automatic model_accept(input logic [IW-1:0] d, input logic l, input int ec);
      logic [OW-1:0] w;
      m_asm[m_idx] = d;
      if (m_idx == R - 1 || l) begin
         w = '0;
         for (int i = 0; i < R; i++) w[i*IW +: IW] = m_asm[i];
         exp_q.push_back(w);
         exp_cyc_q.push_back(ec);
         foreach (m_asm[i]) m_asm[i] = '0;
         m_idx = 0;
      end else begin
         m_idx++;
      end
   endtask

   // Offer one beat from posedge+1; returns at posedge+1 after acceptance.
   task automatic send(input logic [IW-1:0] d, input logic l);
      int acc = 0;
      bit ok  = 1'b0;
      snk_valid = 1'b1;
      snk_data  = d;
      snk_last  = l;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (snk_ready) begin
            ok  = 1'b1;
            acc = cyc;
            break;
         end
         stalls++;
      end
      if (!ok) begin
         check("send_timeout", {{(OW-1){1'b0}}, snk_ready}, 1);
         snk_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      snk_valid = 1'b0;
      snk_last  = 1'b0;
      model_accept(d, l, fifo_full ? -1 : acc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_en", fifo_wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", snk_ready, 1);
      check("rst_wr_data", fifo_wr_data, '0);
      rst = 1'b0;
      idle(1);

      // Async reset while a word is pending behind a full FIFO.
      fifo_full = 1'b1;
      for (int i = 1; i <= 4; i++) send(IW'(32'h50 + i), 1'b0);
      @(negedge clk);
      check("pend_ready", snk_ready, 0);
      check("pend_wr_en", fifo_wr_en, 0);
      check("pend_busy", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_wr_en", fifo_wr_en, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_ready", snk_ready, 1);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      fifo_full = 1'b0;
      idle(4);
      check("async_rst_no_write", wr_count, 0);

      // Full word.
      base = wr_count;
      send(32'h11, 1'b0);
      send(32'h22, 1'b0);
      send(32'h33, 1'b0);
      send(32'h44, 1'b0);
      idle(3);
      check("full_word_count", wr_count - base, 1);
      check("full_word_busy", busy, 0);

      // Partial word closed by last, then a full word.
      base = wr_count;
      send(32'hA, 1'b0);
      check("partial_busy", busy, 1);
      send(32'hB, 1'b1);
      for (int i = 1; i <= 4; i++) send(IW'(i), 1'b0);
      idle(3);
      check("partial_count", wr_count - base, 2);
      check("partial_busy_end", busy, 0);

      // Last on lane 0 and on lane 3.
      base = wr_count;
      send(32'hF0, 1'b1);
      for (int i = 0; i < 4; i++) send(IW'(32'hE0 + i), i == 3);
      idle(3);
      check("last_edges_count", wr_count - base, 2);

      // Back-pressure.
      base = wr_count;
      fifo_full = 1'b1;
      for (int i = 1; i <= 4; i++) send(IW'(32'h60 + i), 1'b0);
      snk_valid = 1'b1;
      snk_data  = 32'h65;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_stall_ready", snk_ready, 0);
         check("bp_stall_wr_en", fifo_wr_en, 0);
      end
      @(posedge clk);
      #1;
      fifo_full = 1'b0;
      #1;
      check("bp_release_wr_en", fifo_wr_en, 1);
      check("bp_release_ready", snk_ready, 1);
      for (int i = 5; i <= 8; i++) send(IW'(32'h60 + i), 1'b0);
      idle(3);
      check("bp_count", wr_count - base, 2);

      // Streaming.
      base   = wr_count;
      stalls = 0;
      for (int i = 1; i <= 8; i++) send(IW'(i), 1'b0);
      idle(3);
      check("stream_count", wr_count - base, 2);
      check("stream_stalls", stalls, 0);
      if (wr_cyc_hist.size() >= 2)
         check("stream_spacing", wr_cyc_hist[wr_cyc_hist.size()-1] - wr_cyc_hist[wr_cyc_hist.size()-2], 4);

      // Reset mid-word.
      send(32'hC, 1'b0);
      send(32'hD, 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      model_reset();
      #2;
      rst = 1'b0;
      idle(1);
      base = wr_count;
      for (int i = 1; i <= 4; i++) send(IW'(i), 1'b0);
      idle(3);
      check("midrst_count", wr_count - base, 1);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
